// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encoding and
// the bit-counter width helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Counter must index bits 0..WIDTH-1 and never be zero-width.
  function automatic int CNT_W(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell; the only arithmetic in the serial datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// LSB-first bit-serial adder/subtractor: one full-adder cell and a carry flop,
// WIDTH cycles per operation.
//
// Handshake: start is a request sampled only while idle (busy=0); the operands,
// sub and cin are captured on that edge and may change afterwards. busy stays
// high until the result is delivered, and done pulses for exactly one cycle
// with sum/Cout/ovf valid; those outputs hold until the next completion.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             Cout,
  output logic             ovf,
  output state_t           dbg_state
);

  localparam int            CW   = CNT_W(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] psum_q;
  logic [WIDTH-1:0] psum_next;
  logic             fa_s;
  logic             fa_co;
  logic             last_bit;

  full_adder u_fa (
    .a  (opa_q[0]),
    .b  (opb_q[0]),
    .c  (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last_bit  = (cnt_q == LAST);
  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  assign psum_next = (psum_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      psum_q  <= '0;
      sum     <= '0;
      Cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            // Subtraction is A + ~B + 1: invert B and force the initial carry.
            opa_q   <= inA;
            opb_q   <= sub ? ~inB : inB;
            carry_q <= sub ? 1'b1 : cin;
            cnt_q   <= '0;
            psum_q  <= '0;
          end
        end
        RUN: begin
          opa_q   <= opa_q >> 1;
          opb_q   <= opb_q >> 1;
          carry_q <= fa_co;
          psum_q  <= psum_next;
          if (last_bit) begin
            // carry_q is the carry into the MSB, fa_co the carry out of it.
            sum  <= psum_next;
            Cout <= fa_co;
            ovf  <= carry_q ^ fa_co;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8 and WIDTH=1 builds) and the
// full_adder cell, against an arithmetic reference model.
module tb_serial_adder;
  import serial_adder_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic         start, sub, cin;
  logic [W-1:0] in_a, in_b;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;
  state_t       dbg_state;

  logic         start1, sub1, cin1;
  logic [0:0]   in_a1, in_b1;
  logic         busy1, done1, cout1, ovf1;
  logic [0:0]   sum1;
  state_t       dbg_state1;

  logic fa_a, fa_b, fa_c, fa_s, fa_co;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] last_sum = '0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .inA(in_a), .inB(in_b),
    .cin(cin), .busy(busy), .done(done), .sum(sum), .Cout(cout), .ovf(ovf),
    .dbg_state(dbg_state)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .inA(in_a1), .inB(in_b1),
    .cin(cin1), .busy(busy1), .done(done1), .sum(sum1), .Cout(cout1), .ovf(ovf1),
    .dbg_state(dbg_state1)
  );

  full_adder u_fa (.a(fa_a), .b(fa_b), .c(fa_c), .s(fa_s), .co(fa_co));

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic void model(input int w, input longint unsigned a, b,
                                input bit c, s, output longint unsigned r,
                                output bit co, output bit ov);
    longint unsigned md;
    longint sa, sb, res;
    md = 64'd1 << w;
    sa = longint'(a);
    sb = longint'(b);
    if (a >= md / 2) sa = sa - longint'(md);
    if (b >= md / 2) sb = sb - longint'(md);
    if (s) begin
      res = sa - sb;
      r   = (a + md - b) % md;
      co  = (a >= b);
    end else begin
      res = sa + sb + longint'(c);
      r   = (a + b + c) % md;
      co  = ((a + b + c) >= md);
    end
    ov = (res > longint'(md / 2) - 1) || (res < -longint'(md / 2));
  endfunction

  // Launches one operation on the WIDTH=8 instance and waits for done.
  task automatic run_op(input logic [W-1:0] a, b, input logic c, s,
                        input logic [W-1:0] prev_sum, output int edges,
                        output int busy_cycles, output logic held);
    start = 1'b1; in_a = a; in_b = b; cin = c; sub = s;
    @(posedge clk); #1;
    start = 1'b0; in_a = W'($urandom); in_b = W'($urandom);
    cin = 1'($urandom); sub = 1'($urandom);
    edges = 1;
    busy_cycles = int'(busy);
    held = 1'b1;
    while (!done && edges < 40) begin
      if (sum !== prev_sum) held = 1'b0;
      @(posedge clk); #1;
      edges++;
      if (busy) busy_cycles++;
    end
    if (!done) edges = -1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, sum, cout, ovf} !== '0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_values got busy=%b done=%b sum=%h cout=%b ovf=%b st=%0d want all 0",
               busy, done, sum, cout, ovf, dbg_state);
    end
    checks++;
    if ({busy1, done1, sum1, cout1, ovf1} !== '0 || dbg_state1 !== IDLE) begin
      errors++;
      $display("FAIL reset_values_w1 got busy=%b done=%b sum=%b want all 0", busy1, done1, sum1);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL idle_without_start got busy=%b want 0", busy);
    end
  endtask

  task automatic test_full_adder();
    for (int i = 0; i < 8; i++) begin
      int n;
      fa_a = i[0]; fa_b = i[1]; fa_c = i[2];
      n = int'(fa_a) + int'(fa_b) + int'(fa_c);
      #1;
      checks++;
      if (fa_s !== 1'(n % 2) || fa_co !== (n >= 2)) begin
        errors++;
        $display("FAIL full_adder abc=%0d got s=%b co=%b want s=%b co=%b",
                 i, fa_s, fa_co, 1'(n % 2), (n >= 2));
      end
    end
  endtask

  logic [W-1:0] ta [5] = '{8'h5A, 8'hFF, 8'h00, 8'h10, 8'h80};
  logic [W-1:0] tb_ [5] = '{8'h3C, 8'h01, 8'h00, 8'h20, 8'h01};
  logic         tc [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic         ts [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [W-1:0] es [5] = '{8'h96, 8'h00, 8'h01, 8'hF0, 8'h7F};
  logic         ec [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic         eo [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  task automatic test_directed();
    for (int i = 0; i < 5; i++) begin
      int edges, bc;
      logic held;
      run_op(ta[i], tb_[i], tc[i], ts[i], last_sum, edges, bc, held);
      checks++;
      if (edges !== W + 1 || bc !== W + 1) begin
        errors++;
        $display("FAIL directed%0d_latency got edges=%0d busy=%0d want %0d", i, edges, bc, W + 1);
      end
      checks++;
      if (!held) begin
        errors++;
        $display("FAIL directed%0d_sum_hold got partial sum visible want held %h", i, last_sum);
      end
      checks++;
      if (sum !== es[i] || cout !== ec[i] || ovf !== eo[i]) begin
        errors++;
        $display("FAIL directed%0d_result got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                 i, sum, cout, ovf, es[i], ec[i], eo[i]);
      end
      last_sum = es[i];
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || sum !== es[i]) begin
        errors++;
        $display("FAIL directed%0d_after_done got done=%b busy=%b sum=%h want 0 0 %h",
                 i, done, busy, sum, es[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] a, b;
      logic c, s, held;
      longint unsigned r;
      bit co, ov;
      int edges, bc;
      a = W'($urandom); b = W'($urandom); c = 1'($urandom); s = 1'($urandom);
      model(W, a, b, c, s, r, co, ov);
      run_op(a, b, c, s, last_sum, edges, bc, held);
      checks++;
      if (edges !== W + 1 || !held) begin
        errors++;
        $display("FAIL random%0d_timing got edges=%0d held=%b want %0d 1", i, edges, held, W + 1);
      end
      checks++;
      if (sum !== W'(r) || cout !== co || ovf !== ov) begin
        errors++;
        $display("FAIL random%0d a=%h b=%h c=%b sub=%b got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                 i, a, b, c, s, sum, cout, ovf, W'(r), co, ov);
      end
      last_sum = W'(r);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_busy_ignore();
    int edges;
    logic quiet;
    start = 1'b1; in_a = 8'h5A; in_b = 8'h3C; cin = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1;
    repeat (2) begin @(posedge clk); #1; edges++; end
    start = 1'b1; in_a = 8'h11; in_b = 8'h22; cin = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    edges++;
    start = 1'b0;
    while (!done && edges < 40) begin @(posedge clk); #1; edges++; end
    checks++;
    if (edges !== W + 1 || sum !== 8'h96 || cout !== 1'b0 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL busy_ignore got edges=%0d sum=%h cout=%b ovf=%b want %0d 96 0 1",
               edges, sum, cout, ovf, W + 1);
    end
    last_sum = 8'h96;
    quiet = 1'b1;
    repeat (W + 3) begin
      @(posedge clk); #1;
      if (busy || done) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL busy_ignore_no_second_op got activity want idle");
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a1, b1, a2, b2;
    longint unsigned r1, r2;
    bit co1, ov1, co2, ov2;
    int edges;
    logic held;
    a1 = W'($urandom); b1 = W'($urandom); a2 = W'($urandom); b2 = W'($urandom);
    model(W, a1, b1, 1'b1, 1'b0, r1, co1, ov1);
    model(W, a2, b2, 1'b0, 1'b1, r2, co2, ov2);
    start = 1'b1; in_a = a1; in_b = b1; cin = 1'b1; sub = 1'b0;
    @(posedge clk); #1;
    in_a = a2; in_b = b2; cin = 1'b0; sub = 1'b1;
    edges = 1;
    while (!done && edges < 40) begin @(posedge clk); #1; edges++; end
    checks++;
    if (edges !== W + 1 || sum !== W'(r1) || cout !== co1 || ovf !== ov1) begin
      errors++;
      $display("FAIL b2b_first got edges=%0d sum=%h cout=%b ovf=%b want %0d %h %b %b",
               edges, sum, cout, ovf, W + 1, W'(r1), co1, ov1);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_gap got busy=%b done=%b want 0 0", busy, done);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_start got busy=%b want 1", busy);
    end
    edges = 1;
    held = 1'b1;
    while (!done && edges < 40) begin
      if (sum !== W'(r1)) held = 1'b0;
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
    checks++;
    if (edges !== W + 1 || !held || sum !== W'(r2) || cout !== co2 || ovf !== ov2) begin
      errors++;
      $display("FAIL b2b_second got edges=%0d held=%b sum=%h cout=%b ovf=%b want %0d 1 %h %b %b",
               edges, held, sum, cout, ovf, W + 1, W'(r2), co2, ov2);
    end
    last_sum = W'(r2);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int edges, bc;
    logic held, quiet;
    start = 1'b1; in_a = 8'h5A; in_b = 8'h3C; cin = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, sum, cout, ovf} !== '0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_mid_async got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
               busy, done, sum, cout, ovf);
    end
    quiet = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      if (busy || done) quiet = 1'b0;
    end
    #2 rst_n = 1'b1;
    repeat (W + 2) begin
      @(posedge clk); #1;
      if (busy || done) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL reset_mid_no_done got activity after abort want none");
    end
    last_sum = '0;
    run_op(8'h01, 8'h02, 1'b0, 1'b0, last_sum, edges, bc, held);
    checks++;
    if (edges !== W + 1 || sum !== 8'h03 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_fresh_op got edges=%0d sum=%h cout=%b ovf=%b want %0d 03 0 0",
               edges, sum, cout, ovf, W + 1);
    end
    last_sum = 8'h03;
    @(posedge clk); #1;
  endtask

  task automatic test_width1();
    logic [0:0] prev;
    prev = 1'b0;
    for (int i = 0; i < 16; i++) begin
      longint unsigned r;
      bit co, ov;
      int edges;
      model(1, longint'(i[0]), longint'(i[1]), i[2], i[3], r, co, ov);
      start1 = 1'b1; in_a1 = i[0]; in_b1 = i[1]; cin1 = i[2]; sub1 = i[3];
      @(posedge clk); #1;
      start1 = 1'b0; in_a1 = 1'($urandom); in_b1 = 1'($urandom);
      edges = 1;
      while (!done1 && edges < 10) begin @(posedge clk); #1; edges++; end
      checks++;
      if (edges !== 2 || sum1 !== 1'(r) || cout1 !== co || ovf1 !== ov) begin
        errors++;
        $display("FAIL width1_%0d got edges=%0d sum=%b cout=%b ovf=%b want 2 %b %b %b",
                 i, edges, sum1, cout1, ovf1, 1'(r), co, ov);
      end
      prev = 1'(r);
      @(posedge clk); #1;
      checks++;
      if (done1 !== 1'b0 || busy1 !== 1'b0 || sum1 !== prev) begin
        errors++;
        $display("FAIL width1_%0d_after_done got done=%b busy=%b sum=%b want 0 0 %b",
                 i, done1, busy1, sum1, prev);
      end
    end
  endtask

  initial begin
    start = 1'b0; sub = 1'b0; cin = 1'b0; in_a = '0; in_b = '0;
    start1 = 1'b0; sub1 = 1'b0; cin1 = 1'b0; in_a1 = '0; in_b1 = '0;
    fa_a = 1'b0; fa_b = 1'b0; fa_c = 1'b0;
    test_reset();
    test_full_adder();
    test_directed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_width1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
